layer_sched_a: RTL

- Sequencer that time-multiplexes one shared `neuron_a` datapath (Q8.24, 3 inputs, tanh) across the N_NEURONS neurons of one layer.
- Accepts one 3-element activation vector via valid/ready and fetches each neuron's weights and bias from a synchronous weight memory.
- Drives the shared neuron's inputs, captures each result, and presents the whole layer output vector via valid/ready.
- Sits between consecutive layers in the network top; the `neuron_a` instance lives in the parent.

---
 rtl/nn_pkg.sv | 15 +
 rtl/layer_sched_a.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// Shared fixed-point constants and the layer-sequencer state encoding.
package nn_pkg;

    localparam int          WIDTH = 32;
    localparam int          FBITS = 24;
    localparam logic [31:0] ONE   = 32'h0100_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/layer_sched_a.sv
// Layer sequencer: runs each neuron of one layer through a shared external
// neuron datapath, fetching weights per neuron and collecting the outputs.
module layer_sched_a
    import nn_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_NEURONS = 3,
    parameter int AW        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a1,
    input  logic [WIDTH-1:0]             in_a2,
    input  logic [WIDTH-1:0]             in_a3,
    output logic                         w_en,
    output logic [AW-1:0]                w_addr,
    input  logic [4*WIDTH-1:0]           w_rdata,
    output logic [WIDTH-1:0]             n_a1,
    output logic [WIDTH-1:0]             n_a2,
    output logic [WIDTH-1:0]             n_a3,
    output logic [WIDTH-1:0]             n_w1,
    output logic [WIDTH-1:0]             n_w2,
    output logic [WIDTH-1:0]             n_w3,
    output logic [WIDTH-1:0]             n_b,
    input  logic [WIDTH-1:0]             n_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_NEURONS*WIDTH-1:0]   y_flat,
    output logic                         busy
);

    sched_state_t               r_state;
    sched_state_t               w_next;
    logic [AW-1:0]              r_idx;
    logic [WIDTH-1:0]           r_a1, r_a2, r_a3;
    logic [WIDTH-1:0]           r_w1, r_w2, r_w3, r_b;
    logic [N_NEURONS*WIDTH-1:0] r_y;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_eval;

    assign w_last   = (r_idx == AW'(N_NEURONS - 1));
    assign w_eval   = (r_state == S_EVAL);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_en      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_FETCH;
            end
            S_FETCH: begin
                busy   = 1'b1;
                w_en   = 1'b1;
                w_next = S_EVAL;
            end
            S_EVAL: begin
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_a3    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_b     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a1  <= in_a1;
                r_a2  <= in_a2;
                r_a3  <= in_a3;
                r_idx <= '0;
            end
            if (w_eval) begin
                // Weight copies keep n_w*/n_b stable once the memory read data moves on.
                r_w1 <= w_rdata[0*WIDTH +: WIDTH];
                r_w2 <= w_rdata[1*WIDTH +: WIDTH];
                r_w3 <= w_rdata[2*WIDTH +: WIDTH];
                r_b  <= w_rdata[3*WIDTH +: WIDTH];
                for (int unsigned k = 0; k < N_NEURONS; k++) begin
                    if (r_idx == AW'(k)) r_y[k*WIDTH +: WIDTH] <= n_y;
                end
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign w_addr = r_idx;
    assign n_a1   = r_a1;
    assign n_a2   = r_a2;
    assign n_a3   = r_a3;
    assign n_w1   = w_eval ? w_rdata[0*WIDTH +: WIDTH] : r_w1;
    assign n_w2   = w_eval ? w_rdata[1*WIDTH +: WIDTH] : r_w2;
    assign n_w3   = w_eval ? w_rdata[2*WIDTH +: WIDTH] : r_w3;
    assign n_b    = w_eval ? w_rdata[3*WIDTH +: WIDTH] : r_b;
    assign y_flat = r_y;

endmodule
